// File: rtl/lcd_timing_ctrl.sv
// lcd_timing_ctrl: dot/line sequencer for the LCD path.
// Counts dots and lines on the dot-rate enable, decodes the PPU mode, and
// generates the pixel strobe, LY/LYC compare and the vblank/STAT interrupts.
// Every output is a register loaded from the *next* dot/line, so mode,
// pix_ena and pix_x always agree with dot/ly in the same cycle.
`timescale 1ns/1ps

module lcd_timing_ctrl #(
  parameter int DOTS_PER_LINE = 456,
  parameter int LINES         = 154,
  parameter int VISIBLE_LINES = 144,
  parameter int OAM_DOTS      = 80,
  parameter int XFER_DOTS     = 172,
  parameter int PIX_DELAY     = 12,
  parameter int H_PIXELS      = 160
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       lcd_on,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_ie,
  output logic [1:0] mode,
  output logic [7:0] ly,
  output logic [8:0] dot,
  output logic       pix_ena,
  output logic [7:0] pix_x,
  output logic       lyc_match,
  output logic       irq_vblank,
  output logic       irq_stat,
  output logic       frame_start
);

  // PPU mode encodings as seen by the CPU in STAT[1:0]
  localparam logic [1:0] MODE_HBLANK = 2'b00;
  localparam logic [1:0] MODE_VBLANK = 2'b01;
  localparam logic [1:0] MODE_OAM    = 2'b10;
  localparam logic [1:0] MODE_XFER   = 2'b11;

  // Dot/line landmarks, pre-sized to the counter widths
  localparam logic [8:0] DOT_LAST      = 9'(DOTS_PER_LINE - 1);
  localparam logic [7:0] LY_LAST       = 8'(LINES - 1);
  localparam logic [7:0] LY_VBLANK     = 8'(VISIBLE_LINES);
  localparam logic [8:0] DOT_XFER      = 9'(OAM_DOTS);
  localparam logic [8:0] DOT_HBLANK    = 9'(OAM_DOTS + XFER_DOTS);
  localparam logic [8:0] DOT_PIX_FIRST = 9'(OAM_DOTS + PIX_DELAY);
  localparam logic [8:0] DOT_PIX_END   = 9'(OAM_DOTS + PIX_DELAY + H_PIXELS);

  // Sequencer state: idle while the LCD is off, run once the first dot enable arrives
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [8:0] r_dot;
  logic [7:0] r_ly;
  logic [1:0] r_mode;
  logic       r_pix_ena;
  logic [7:0] r_pix_x;
  logic       r_lyc_match;
  logic       r_irq_vblank;
  logic       r_irq_stat;
  logic       r_frame_start;
  logic       r_stat_line;

  logic [8:0] w_dot_nxt;
  logic [7:0] w_ly_nxt;
  logic [1:0] w_mode_nxt;
  logic       w_pix_nxt;
  logic [7:0] w_pix_x_nxt;
  logic       w_lyc_hit;
  logic       w_stat_nxt;
  logic       w_vbl_hit;
  logic       w_frame_hit;

  // Mode of a given position: vblank lines first, then OAM / transfer / hblank by dot
  function automatic logic [1:0] mode_decode(input logic [8:0] d, input logic [7:0] l);
    logic [1:0] m;
    if (l >= LY_VBLANK) begin
      m = MODE_VBLANK;
    end else if (d < DOT_XFER) begin
      m = MODE_OAM;
    end else if (d < DOT_HBLANK) begin
      m = MODE_XFER;
    end else begin
      m = MODE_HBLANK;
    end
    return m;
  endfunction

  // True while the position lies inside the visible pixel window of a visible line
  function automatic logic pix_window(input logic [8:0] d, input logic [7:0] l);
    return (l < LY_VBLANK) && (d >= DOT_PIX_FIRST) && (d < DOT_PIX_END);
  endfunction

  // Combined STAT request level from the enabled sources
  function automatic logic stat_level(input logic [1:0] m, input logic hit, input logic [3:0] ie);
    return (ie[0] && (m == MODE_HBLANK)) ||
           (ie[1] && (m == MODE_VBLANK)) ||
           (ie[2] && (m == MODE_OAM))    ||
           (ie[3] && hit);
  endfunction

  // Next-state logic: LCD off forces idle, any dot enable while on means running
  always_comb begin
    w_state_nxt = r_state;
    if (!lcd_on) begin
      w_state_nxt = ST_IDLE;
    end else if (ce) begin
      w_state_nxt = ST_RUN;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next dot/line position; a frame start from idle begins at line 0, dot 0
  always_comb begin
    w_dot_nxt = r_dot;
    w_ly_nxt  = r_ly;
    case (r_state)
      ST_IDLE: begin
        w_dot_nxt = 9'd0;
        w_ly_nxt  = 8'd0;
      end
      ST_RUN: begin
        if (r_dot == DOT_LAST) begin
          w_dot_nxt = 9'd0;
          if (r_ly == LY_LAST) begin
            w_ly_nxt = 8'd0;
          end else begin
            w_ly_nxt = r_ly + 8'd1;
          end
        end else begin
          w_dot_nxt = r_dot + 9'd1;
          w_ly_nxt  = r_ly;
        end
      end
      default: begin
        w_dot_nxt = 9'd0;
        w_ly_nxt  = 8'd0;
      end
    endcase
  end

  // Output decode from the next position so registered outputs line up with dot/ly
  always_comb begin
    w_mode_nxt  = mode_decode(w_dot_nxt, w_ly_nxt);
    w_pix_nxt   = pix_window(w_dot_nxt, w_ly_nxt);
    w_pix_x_nxt = 8'd0;
    if (w_pix_nxt) begin
      w_pix_x_nxt = 8'(w_dot_nxt - DOT_PIX_FIRST);
    end else begin
      w_pix_x_nxt = 8'd0;
    end
    w_lyc_hit   = (w_ly_nxt == lyc);
    w_stat_nxt  = stat_level(w_mode_nxt, w_lyc_hit, stat_ie);
    w_vbl_hit   = (w_ly_nxt == LY_VBLANK) && (w_dot_nxt == 9'd0);
    w_frame_hit = (w_ly_nxt == 8'd0) && (w_dot_nxt == 9'd0);
  end

  // Position, mode and pulse registers: cleared when off, advanced on each dot enable,
  // and pulses dropped on clocks without an enable so every strobe is one clk wide
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dot         <= 9'd0;
      r_ly          <= 8'd0;
      r_mode        <= MODE_HBLANK;
      r_pix_ena     <= 1'b0;
      r_pix_x       <= 8'd0;
      r_lyc_match   <= 1'b0;
      r_irq_vblank  <= 1'b0;
      r_irq_stat    <= 1'b0;
      r_frame_start <= 1'b0;
      r_stat_line   <= 1'b0;
    end else if (!lcd_on) begin
      r_dot         <= 9'd0;
      r_ly          <= 8'd0;
      r_mode        <= MODE_HBLANK;
      r_pix_ena     <= 1'b0;
      r_pix_x       <= 8'd0;
      r_lyc_match   <= 1'b0;
      r_irq_vblank  <= 1'b0;
      r_irq_stat    <= 1'b0;
      r_frame_start <= 1'b0;
      r_stat_line   <= 1'b0;
    end else if (ce) begin
      r_dot         <= w_dot_nxt;
      r_ly          <= w_ly_nxt;
      r_mode        <= w_mode_nxt;
      r_pix_ena     <= w_pix_nxt;
      r_pix_x       <= w_pix_x_nxt;
      r_lyc_match   <= w_lyc_hit;
      r_irq_vblank  <= w_vbl_hit;
      r_irq_stat    <= w_stat_nxt && !r_stat_line;
      r_frame_start <= w_frame_hit;
      r_stat_line   <= w_stat_nxt;
    end else begin
      r_pix_ena     <= 1'b0;
      r_irq_vblank  <= 1'b0;
      r_irq_stat    <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign mode        = r_mode;
  assign ly          = r_ly;
  assign dot         = r_dot;
  assign pix_ena     = r_pix_ena;
  assign pix_x       = r_pix_x;
  assign lyc_match   = r_lyc_match;
  assign irq_vblank  = r_irq_vblank;
  assign irq_stat    = r_irq_stat;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Bench for lcd_timing_ctrl, built with a shrunken geometry so whole frames are cheap.
// The model tracks only "dot enables since frame start" and derives every output
// from that count with plain arithmetic.
`timescale 1ns/1ps

module tb_lcd_timing_ctrl;

  localparam int DPL   = 60;
  localparam int LNS   = 20;
  localparam int VIS   = 14;
  localparam int OAM   = 10;
  localparam int XFER  = 24;
  localparam int PD    = 4;
  localparam int HP    = 16;
  localparam int FRAME = DPL * LNS;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       reset_n;
  logic       ce;
  logic       lcd_on;
  logic [7:0] lyc;
  logic [3:0] stat_ie;
  logic [1:0] mode;
  logic [7:0] ly;
  logic [8:0] dot;
  logic       pix_ena;
  logic [7:0] pix_x;
  logic       lyc_match;
  logic       irq_vblank;
  logic       irq_stat;
  logic       frame_start;

  lcd_timing_ctrl #(
    .DOTS_PER_LINE(DPL), .LINES(LNS), .VISIBLE_LINES(VIS), .OAM_DOTS(OAM),
    .XFER_DOTS(XFER), .PIX_DELAY(PD), .H_PIXELS(HP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .lcd_on(lcd_on), .lyc(lyc), .stat_ie(stat_ie),
    .mode(mode), .ly(ly), .dot(dot), .pix_ena(pix_ena), .pix_x(pix_x),
    .lyc_match(lyc_match), .irq_vblank(irq_vblank), .irq_stat(irq_stat),
    .frame_start(frame_start)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // model state
  bit m_run, m_match, m_stat_q, ce_ev;
  int m_n;
  int e_dot, e_ly, e_mode, e_pix_x;
  bit e_pix, e_match, e_stat, e_vbl, e_fs;

  // statistics gathered from DUT outputs
  int cnt_m [4];
  int cnt_pix, cnt_vbl, cnt_stat, cnt_fs, cnt_match;
  int ce_since_fs, fs_period, pix0_dot, last_pix_x, vbl_ly, vbl_dot, stat_ly, stat_dot;
  int s_m [4];
  int s_pix, s_vbl, s_stat, s_fs, s_match;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_update();
    bit lvl;
    ce_ev = 1'b0;
    if (!reset_n || !lcd_on) begin
      m_run = 1'b0; m_n = 0; m_match = 1'b0; m_stat_q = 1'b0;
    end else if (ce) begin
      ce_ev = 1'b1;
      if (!m_run) begin m_run = 1'b1; m_n = 0; end
      else m_n = (m_n + 1) % FRAME;
    end
    e_dot = m_run ? m_n % DPL : 0;
    e_ly  = m_run ? m_n / DPL : 0;
    if (!m_run)                  e_mode = 0;
    else if (e_ly >= VIS)        e_mode = 1;
    else if (e_dot < OAM)        e_mode = 2;
    else if (e_dot < OAM + XFER) e_mode = 3;
    else                         e_mode = 0;
    e_pix   = ce_ev && (e_ly < VIS) && (e_dot >= OAM + PD) && (e_dot < OAM + PD + HP);
    e_pix_x = e_dot - (OAM + PD);
    if (ce_ev) m_match = (e_ly == int'(lyc));
    e_match = m_match;
    e_stat  = 1'b0;
    if (ce_ev) begin
      lvl = (stat_ie[0] && e_mode == 0) || (stat_ie[1] && e_mode == 1) ||
            (stat_ie[2] && e_mode == 2) || (stat_ie[3] && m_match);
      e_stat   = lvl && !m_stat_q;
      m_stat_q = lvl;
    end
    e_vbl = ce_ev && (e_ly == VIS) && (e_dot == 0);
    e_fs  = ce_ev && (m_n == 0);
  endtask

  task automatic compare();
    check("dot", int'(dot), e_dot);
    check("ly", int'(ly), e_ly);
    check("mode", int'(mode), e_mode);
    check("pix_ena", int'(pix_ena), int'(e_pix));
    if (e_pix) check("pix_x", int'(pix_x), e_pix_x);
    check("lyc_match", int'(lyc_match), int'(e_match));
    check("irq_vblank", int'(irq_vblank), int'(e_vbl));
    check("irq_stat", int'(irq_stat), int'(e_stat));
    check("frame_start", int'(frame_start), int'(e_fs));
  endtask

  task automatic gather();
    if (ce_ev) begin
      cnt_m[mode]++;
      if (lyc_match) cnt_match++;
      ce_since_fs++;
    end
    if (pix_ena) begin
      cnt_pix++;
      last_pix_x = int'(pix_x);
      if (pix_x == 8'd0) pix0_dot = int'(dot);
    end
    if (irq_vblank) begin cnt_vbl++; vbl_ly = int'(ly); vbl_dot = int'(dot); end
    if (irq_stat) begin cnt_stat++; stat_ly = int'(ly); stat_dot = int'(dot); end
    if (frame_start) begin cnt_fs++; fs_period = ce_since_fs; ce_since_fs = 0; end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare();
    gather();
  endtask

  task automatic snap();
    for (int i = 0; i < 4; i++) s_m[i] = cnt_m[i];
    s_pix = cnt_pix; s_vbl = cnt_vbl; s_stat = cnt_stat; s_fs = cnt_fs; s_match = cnt_match;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) cnt_m[i] = 0;
    cnt_pix = 0; cnt_vbl = 0; cnt_stat = 0; cnt_fs = 0; cnt_match = 0;
    ce_since_fs = 0; fs_period = -1; pix0_dot = -1; last_pix_x = -1;
    vbl_ly = -1; vbl_dot = -1; stat_ly = -1; stat_dot = -1;

    // reset state
    reset_n = 1'b0; lcd_on = 1'b0; ce = 1'b0; lyc = 8'd200; stat_ie = 4'b0000;
    repeat (3) step();
    check("rst_mode", int'(mode), 0);
    check("rst_ly", int'(ly), 0);
    check("rst_dot", int'(dot), 0);

    // line 0 with ce every clk
    reset_n = 1'b1; lcd_on = 1'b1; ce = 1'b1;
    snap();
    step();
    check("start_fs", int'(frame_start), 1);
    check("start_mode", int'(mode), 2);
    repeat (DPL - 1) step();
    check("l0_oam_dots", cnt_m[2] - s_m[2], 10);
    check("l0_xfer_dots", cnt_m[3] - s_m[3], 24);
    check("l0_hblank_dots", cnt_m[0] - s_m[0], 26);
    check("l0_pix_count", cnt_pix - s_pix, 16);
    check("l0_first_pix_dot", pix0_dot, 14);
    check("l0_last_pix_x", last_pix_x, 15);

    // two frames
    snap();
    repeat (2 * FRAME) step();
    check("fr_fs_count", cnt_fs - s_fs, 2);
    check("fr_period", fs_period, 1200);
    check("fr_vbl_count", cnt_vbl - s_vbl, 2);
    check("fr_vbl_ly", vbl_ly, 14);
    check("fr_vbl_dot", vbl_dot, 0);
    check("fr_vblank_dots", cnt_m[1] - s_m[1], 720);

    // LYC source only
    lyc = 8'd5; stat_ie = 4'b1000;
    snap();
    repeat (FRAME) step();
    check("lyc_stat_count", cnt_stat - s_stat, 1);
    check("lyc_stat_ly", stat_ly, 5);
    check("lyc_stat_dot", stat_dot, 0);
    check("lyc_match_dots", cnt_match - s_match, 60);

    // hblank + vblank sources: vblank entry is blocked by the preceding hblank
    lyc = 8'd200; stat_ie = 4'b0011;
    snap();
    repeat (FRAME) step();
    check("hb_stat_count", cnt_stat - s_stat, 14);
    check("hb_stat_dot", stat_dot, 34);
    check("hb_vbl_count", cnt_vbl - s_vbl, 1);

    // vblank entry coinciding with LYC hit
    lyc = 8'd14; stat_ie = 4'b1010;
    snap();
    repeat (FRAME) step();
    check("co_stat_count", cnt_stat - s_stat, 1);
    check("co_stat_ly", stat_ly, 14);
    check("co_vbl_count", cnt_vbl - s_vbl, 1);

    // LCD off mid-frame, then back on
    lyc = 8'd200; stat_ie = 4'b0000;
    for (int k = 0; k < 2 * FRAME && !(e_ly == 5 && e_dot == 20); k++) step();
    check("off_reach", int'(e_ly == 5 && e_dot == 20), 1);
    lcd_on = 1'b0;
    step();
    check("off_mode", int'(mode), 0);
    check("off_ly", int'(ly), 0);
    check("off_dot", int'(dot), 0);
    check("off_pix", int'(pix_ena), 0);
    step();
    lcd_on = 1'b1; ce = 1'b0;
    step();
    check("on_noce_fs", int'(frame_start), 0);
    ce = 1'b1;
    step();
    check("on_fs", int'(frame_start), 1);
    check("on_mode", int'(mode), 2);

    // async reset in mode 11 with the clock stopped
    for (int k = 0; k < 2 * FRAME && !(e_mode == 3 && e_dot == 20); k++) step();
    check("xfer_reach", int'(mode), 3);
    clk_en = 1'b0;
    #3;
    reset_n = 1'b0;
    #10;
    check("ar_mode", int'(mode), 0);
    check("ar_ly", int'(ly), 0);
    check("ar_dot", int'(dot), 0);
    check("ar_pix_ena", int'(pix_ena), 0);
    check("ar_pix_x", int'(pix_x), 0);
    check("ar_pulses", int'({irq_vblank, irq_stat, frame_start, lyc_match}), 0);
    clk_en = 1'b1;
    repeat (2) step();

    // ce every 4th clk: same line 0 sequence at quarter rate
    reset_n = 1'b1; lcd_on = 1'b1;
    snap();
    for (int i = 0; i < 4 * DPL; i++) begin
      ce = (i % 4 == 0);
      step();
    end
    check("q_oam_dots", cnt_m[2] - s_m[2], 10);
    check("q_xfer_dots", cnt_m[3] - s_m[3], 24);
    check("q_hblank_dots", cnt_m[0] - s_m[0], 26);
    check("q_pix_count", cnt_pix - s_pix, 16);
    check("q_first_pix_dot", pix0_dot, 14);
    ce = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
